// File: rtl/xm_pkg.sv
// Shared types and constants for the X-Makina register-file write-back path.
// Register geometry, the queued write-back entry, and the request source tag.
package xm_pkg;

    localparam int unsigned WORD      = 16;
    localparam int unsigned BYTES     = WORD / 8;
    localparam int unsigned REGISTERS = 8;
    localparam int unsigned AW        = $clog2(REGISTERS);

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [BYTES-1:0] mode;
        logic [WORD-1:0]  data;
    } wb_entry_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    function automatic logic [REGISTERS-1:0] addr_decode(input logic [AW-1:0] addr);
        logic [REGISTERS-1:0] onehot;
        onehot       = '0;
        onehot[addr] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Request, PC-update and register-file write signals of the write-back controller.
// The slave side is the controller; the master side is its environment.
interface regfile_writeback_if;
    import xm_pkg::*;

    logic                 alu_valid_i;
    logic                 alu_ready_o;
    logic [AW-1:0]        alu_addr_i;
    logic [BYTES-1:0]     alu_mode_i;
    logic [WORD-1:0]      alu_data_i;

    logic                 mem_valid_i;
    logic                 mem_ready_o;
    logic [AW-1:0]        mem_addr_i;
    logic [BYTES-1:0]     mem_mode_i;
    logic [WORD-1:0]      mem_data_i;

    logic                 pc_valid_i;
    logic                 pc_ready_o;
    logic [WORD-1:0]      pc_i;

    logic                 rf_wrEn_o;
    logic [BYTES-1:0]     rf_wrMode_o;
    logic [AW-1:0]        rf_wrAddr_o;
    logic [WORD-1:0]      rf_data_o;
    logic                 rf_pcEn_o;
    logic [WORD-1:0]      rf_pc_o;

    logic [REGISTERS-1:0] busy_o;
    logic                 idle_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_mode_i, alu_data_i,
        input  mem_valid_i, mem_addr_i, mem_mode_i, mem_data_i,
        input  pc_valid_i, pc_i,
        output alu_ready_o, mem_ready_o, pc_ready_o,
        output rf_wrEn_o, rf_wrMode_o, rf_wrAddr_o, rf_data_o, rf_pcEn_o, rf_pc_o,
        output busy_o, idle_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_mode_i, alu_data_i,
        output mem_valid_i, mem_addr_i, mem_mode_i, mem_data_i,
        output pc_valid_i, pc_i,
        input  alu_ready_o, mem_ready_o, pc_ready_o,
        input  rf_wrEn_o, rf_wrMode_o, rf_wrAddr_o, rf_data_o, rf_pcEn_o, rf_pc_o,
        input  busy_o, idle_o
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order write-back queue: two enqueue slots per cycle (a ahead of b), one pop,
// and a per-register pending-write map built from the valid entries.
module wb_fifo
    import xm_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_a,
    input  wb_entry_t                    entry_a,
    input  logic                         push_b,
    input  wb_entry_t                    entry_b,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [REGISTERS-1:0]         busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t        q_r [DEPTH];
    logic [DEPTH-1:0] entry_valid_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic [PW-1:0]    wr_ptr_p1_s;
    logic [PW-1:0]    wr_ptr_next_s;
    logic [PW-1:0]    rd_ptr_next_s;
    logic [CW-1:0]    count_next_s;

    // Next pointer and occupancy values; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_p1_s   = wr_ptr_r + PW'(1);
        wr_ptr_next_s = wr_ptr_r + PW'(push_a) + PW'(push_b);
        rd_ptr_next_s = rd_ptr_r + PW'(pop);
        count_next_s  = count_r + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    // Queue storage, valid vector and pointers; a push into a slot overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_r[i] <= '0;
            end
            entry_valid_r <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
        end else begin
            if (pop) begin
                entry_valid_r[rd_ptr_r] <= 1'b0;
            end
            if (push_a) begin
                q_r[wr_ptr_r]           <= entry_a;
                entry_valid_r[wr_ptr_r] <= 1'b1;
            end
            if (push_b) begin
                q_r[wr_ptr_p1_s]           <= entry_b;
                entry_valid_r[wr_ptr_p1_s] <= 1'b1;
            end
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Pending-write map: zero-mode entries never mark their register busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | ({REGISTERS{entry_valid_r[i] & (q_r[i].mode != '0)}}
                           & addr_decode(q_r[i].addr));
        end
    end

    assign head  = q_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller of the X-Makina register file: queues ALU/MEM write-backs,
// retires one per cycle and arbitrates PC updates with a bounded starvation window.
module regfile_writeback
    import xm_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STARVE = 3
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    regfile_writeback_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

    wb_entry_t            alu_entry_s;
    wb_entry_t            mem_entry_s;
    wb_entry_t            entry_a_s;
    wb_entry_t            head_s;
    wb_src_e              first_src_s;
    logic                 alu_fire_s;
    logic                 mem_fire_s;
    logic                 push_a_s;
    logic                 push_b_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 pc_grant_s;
    logic [CW-1:0]        count_s;
    logic [CW-1:0]        free_s;
    logic [REGISTERS-1:0] busy_s;
    logic [SW-1:0]        scnt_r;

    // Readies depend only on queue occupancy, so a request can never be accepted into a full slot.
    always_comb begin
        free_s = DEPTH_C - count_s;
        if (!arstn_i) begin
            bus.alu_ready_o = 1'b0;
            bus.mem_ready_o = 1'b0;
        end else if (free_s >= CW'(2)) begin
            bus.alu_ready_o = 1'b1;
            bus.mem_ready_o = 1'b1;
        end else if (free_s == CW'(1)) begin
            bus.alu_ready_o = 1'b0;
            bus.mem_ready_o = 1'b1;
        end else begin
            bus.alu_ready_o = 1'b0;
            bus.mem_ready_o = 1'b0;
        end
    end

    // Enqueue steering: a MEM request always takes the first slot, ahead of ALU.
    always_comb begin
        alu_entry_s = '{addr: bus.alu_addr_i, mode: bus.alu_mode_i, data: bus.alu_data_i};
        mem_entry_s = '{addr: bus.mem_addr_i, mode: bus.mem_mode_i, data: bus.mem_data_i};
        alu_fire_s  = bus.alu_valid_i & bus.alu_ready_o;
        mem_fire_s  = bus.mem_valid_i & bus.mem_ready_o;
        if (mem_fire_s) begin
            first_src_s = WB_MEM;
        end else begin
            first_src_s = WB_ALU;
        end
        case (first_src_s)
            WB_MEM:  entry_a_s = mem_entry_s;
            WB_ALU:  entry_a_s = alu_entry_s;
            default: entry_a_s = alu_entry_s;
        endcase
        push_a_s = mem_fire_s | alu_fire_s;
        push_b_s = mem_fire_s & alu_fire_s;
    end

    // PC wins when nothing is queued or once the GPR side has used its full streak.
    always_comb begin
        pc_grant_s = arstn_i & bus.pc_valid_i & (empty_s | (scnt_r == STARVE_C));
        pop_s      = ~empty_s & ~pc_grant_s;
    end

    // Starvation counter: counts retires only while a PC update is waiting.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scnt_r <= '0;
        end else if (!bus.pc_valid_i || pc_grant_s) begin
            scnt_r <= '0;
        end else if (pop_s && (scnt_r != STARVE_C)) begin
            scnt_r <= scnt_r + SW'(1);
        end else begin
            scnt_r <= scnt_r;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (arstn_i),
        .push_a  (push_a_s),
        .entry_a (entry_a_s),
        .push_b  (push_b_s),
        .entry_b (alu_entry_s),
        .pop     (pop_s),
        .head    (head_s),
        .empty   (empty_s),
        .count   (count_s),
        .busy    (busy_s)
    );

    // Register-file drive: the queue head is presented directly; a zero-mode head retires silently.
    always_comb begin
        bus.rf_pcEn_o  = pc_grant_s;
        bus.pc_ready_o = pc_grant_s;
        if (arstn_i) begin
            bus.rf_pc_o = bus.pc_i;
        end else begin
            bus.rf_pc_o = '0;
        end
        bus.rf_wrEn_o = pop_s & (head_s.mode != '0);
        if (empty_s) begin
            bus.rf_wrMode_o = '0;
            bus.rf_wrAddr_o = '0;
            bus.rf_data_o   = '0;
        end else begin
            bus.rf_wrMode_o = head_s.mode;
            bus.rf_wrAddr_o = head_s.addr;
            bus.rf_data_o   = head_s.data;
        end
        bus.busy_o = busy_s;
        bus.idle_o = empty_s & ~(arstn_i & bus.pc_valid_i);
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, single/dual enqueue, full queue,
// PC starvation bound, byte and zero-mode writes, and reset mid-stream.
module tb_regfile_writeback;
    import xm_pkg::*;

    logic clk;
    logic arstn;
    int   n_checks;
    int   n_pass;

    regfile_writeback_if bus();

    regfile_writeback #(
        .DEPTH  (4),
        .STARVE (3)
    ) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [2:0] a, input logic [1:0] m, input logic [15:0] d);
        bus.alu_valid_i = v;
        bus.alu_addr_i  = a;
        bus.alu_mode_i  = m;
        bus.alu_data_i  = d;
    endtask

    task automatic set_mem(input logic v, input logic [2:0] a, input logic [1:0] m, input logic [15:0] d);
        bus.mem_valid_i = v;
        bus.mem_addr_i  = a;
        bus.mem_mode_i  = m;
        bus.mem_data_i  = d;
    endtask

    task automatic set_pc(input logic v, input logic [15:0] p);
        bus.pc_valid_i = v;
        bus.pc_i       = p;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [2:0] a, input logic [15:0] d);
        check({tag, "_wren"}, 32'(bus.rf_wrEn_o), 32'(en));
        check({tag, "_addr"}, 32'(bus.rf_wrAddr_o), 32'(a));
        check({tag, "_data"}, 32'(bus.rf_data_o), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        arstn    = 1'b0;
        set_alu(1'b0, 3'd0, 2'b00, 16'h0000);
        set_mem(1'b0, 3'd0, 2'b00, 16'h0000);
        set_pc(1'b0, 16'h0000);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_wren",    32'(bus.rf_wrEn_o),   32'd0);
        check("rst_pcen",    32'(bus.rf_pcEn_o),   32'd0);
        check("rst_data",    32'(bus.rf_data_o),   32'd0);
        check("rst_busy",    32'(bus.busy_o),      32'd0);
        check("rst_idle",    32'(bus.idle_o),      32'd1);
        check("rst_alu_rdy", 32'(bus.alu_ready_o), 32'd0);
        check("rst_mem_rdy", 32'(bus.mem_ready_o), 32'd0);
        cyc();
        arstn = 1'b1;
        @(negedge clk);
        check("rel_alu_rdy", 32'(bus.alu_ready_o), 32'd1);

        // single ALU write
        cyc();
        set_alu(1'b1, 3'd2, 2'b11, 16'hBEEF);
        @(negedge clk);
        check("sw_alu_rdy", 32'(bus.alu_ready_o), 32'd1);
        cyc();
        set_alu(1'b0, 3'd0, 2'b00, 16'h0000);
        @(negedge clk);
        chk_wr("sw", 1'b1, 3'd2, 16'hBEEF);
        check("sw_mode", 32'(bus.rf_wrMode_o), 32'h3);
        check("sw_busy", 32'(bus.busy_o), 32'h04);
        check("sw_idle", 32'(bus.idle_o), 32'd0);
        cyc();
        @(negedge clk);
        check("sw_busy_clr", 32'(bus.busy_o), 32'h00);
        check("sw_wren_clr", 32'(bus.rf_wrEn_o), 32'd0);
        check("sw_idle_end", 32'(bus.idle_o), 32'd1);

        // dual enqueue: MEM retires ahead of ALU
        cyc();
        set_mem(1'b1, 3'd1, 2'b11, 16'h1111);
        set_alu(1'b1, 3'd3, 2'b11, 16'h3333);
        @(negedge clk);
        check("de_mem_rdy", 32'(bus.mem_ready_o), 32'd1);
        check("de_alu_rdy", 32'(bus.alu_ready_o), 32'd1);
        cyc();
        set_mem(1'b0, 3'd0, 2'b00, 16'h0000);
        set_alu(1'b0, 3'd0, 2'b00, 16'h0000);
        @(negedge clk);
        chk_wr("de1", 1'b1, 3'd1, 16'h1111);
        check("de1_busy", 32'(bus.busy_o), 32'h0A);
        cyc();
        @(negedge clk);
        chk_wr("de2", 1'b1, 3'd3, 16'h3333);
        check("de2_busy", 32'(bus.busy_o), 32'h08);
        cyc();
        @(negedge clk);
        check("de_idle", 32'(bus.idle_o), 32'd1);

        // PC starvation bound, free==1 and full queue
        cyc();
        set_pc(1'b1, 16'h0040);
        set_mem(1'b1, 3'd4, 2'b11, 16'h4444);
        set_alu(1'b1, 3'd5, 2'b11, 16'h5555);
        @(negedge clk);
        check("pa_pcen",   32'(bus.rf_pcEn_o),  32'd1);
        check("pa_pcrdy",  32'(bus.pc_ready_o), 32'd1);
        check("pa_pc",     32'(bus.rf_pc_o),    32'h0040);
        check("pa_wren",   32'(bus.rf_wrEn_o),  32'd0);
        check("pa_idle",   32'(bus.idle_o),     32'd0);
        cyc();
        set_mem(1'b1, 3'd6, 2'b11, 16'h6666);
        set_alu(1'b1, 3'd0, 2'b11, 16'h0A0A);
        @(negedge clk);
        chk_wr("pb", 1'b1, 3'd4, 16'h4444);
        check("pb_pcen",    32'(bus.rf_pcEn_o),   32'd0);
        check("pb_alu_rdy", 32'(bus.alu_ready_o), 32'd1);
        check("pb_busy",    32'(bus.busy_o),      32'h30);
        cyc();
        set_mem(1'b1, 3'd1, 2'b11, 16'h1C1C);
        set_alu(1'b1, 3'd2, 2'b11, 16'h2C2C);
        @(negedge clk);
        check("f1_mem_rdy", 32'(bus.mem_ready_o), 32'd1);
        check("f1_alu_rdy", 32'(bus.alu_ready_o), 32'd0);
        chk_wr("pc", 1'b1, 3'd5, 16'h5555);
        check("pc_pcen", 32'(bus.rf_pcEn_o), 32'd0);
        cyc();
        set_mem(1'b1, 3'd7, 2'b11, 16'h7D7D);
        set_alu(1'b0, 3'd0, 2'b00, 16'h0000);
        @(negedge clk);
        chk_wr("pd", 1'b1, 3'd6, 16'h6666);
        check("pd_pcen", 32'(bus.rf_pcEn_o), 32'd0);
        cyc();
        set_mem(1'b1, 3'd3, 2'b11, 16'h3E3E);
        @(negedge clk);
        check("pe_pcen",  32'(bus.rf_pcEn_o),  32'd1);
        check("pe_pcrdy", 32'(bus.pc_ready_o), 32'd1);
        check("pe_pc",    32'(bus.rf_pc_o),    32'h0040);
        check("pe_wren",  32'(bus.rf_wrEn_o),  32'd0);
        cyc();
        set_mem(1'b0, 3'd0, 2'b00, 16'h0000);
        @(negedge clk);
        check("full_mem_rdy", 32'(bus.mem_ready_o), 32'd0);
        check("full_alu_rdy", 32'(bus.alu_ready_o), 32'd0);
        check("full_busy",    32'(bus.busy_o),      32'h8B);
        chk_wr("pf", 1'b1, 3'd0, 16'h0A0A);
        cyc();
        set_pc(1'b0, 16'h0000);
        @(negedge clk);
        check("pg_mem_rdy", 32'(bus.mem_ready_o), 32'd1);
        check("pg_alu_rdy", 32'(bus.alu_ready_o), 32'd0);
        chk_wr("pg", 1'b1, 3'd1, 16'h1C1C);
        cyc();
        @(negedge clk);
        chk_wr("ph", 1'b1, 3'd7, 16'h7D7D);
        cyc();
        @(negedge clk);
        chk_wr("pi", 1'b1, 3'd3, 16'h3E3E);
        cyc();
        @(negedge clk);
        check("pj_wren", 32'(bus.rf_wrEn_o), 32'd0);
        check("pj_idle", 32'(bus.idle_o),    32'd1);

        // byte-mode write followed by a zero-mode entry
        cyc();
        set_mem(1'b1, 3'd2, 2'b01, 16'hAB12);
        set_alu(1'b1, 3'd6, 2'b00, 16'h1234);
        @(negedge clk);
        check("bm_alu_rdy", 32'(bus.alu_ready_o), 32'd1);
        cyc();
        set_mem(1'b0, 3'd0, 2'b00, 16'h0000);
        set_alu(1'b0, 3'd0, 2'b00, 16'h0000);
        @(negedge clk);
        chk_wr("bm", 1'b1, 3'd2, 16'hAB12);
        check("bm_mode", 32'(bus.rf_wrMode_o), 32'h1);
        check("bm_busy", 32'(bus.busy_o),      32'h04);
        cyc();
        @(negedge clk);
        check("z_wren", 32'(bus.rf_wrEn_o),   32'd0);
        check("z_addr", 32'(bus.rf_wrAddr_o), 32'd6);
        check("z_busy", 32'(bus.busy_o),      32'h00);
        check("z_idle", 32'(bus.idle_o),      32'd0);
        cyc();
        @(negedge clk);
        check("z_idle_end", 32'(bus.idle_o), 32'd1);

        // reset with three writes queued
        cyc();
        set_mem(1'b1, 3'd1, 2'b11, 16'hAAAA);
        set_alu(1'b1, 3'd2, 2'b11, 16'hBBBB);
        cyc();
        set_mem(1'b1, 3'd3, 2'b11, 16'hCCCC);
        set_alu(1'b1, 3'd4, 2'b11, 16'hDDDD);
        @(negedge clk);
        check("mr_busy_pre", 32'(bus.busy_o), 32'h06);
        cyc();
        set_mem(1'b0, 3'd0, 2'b00, 16'h0000);
        set_alu(1'b0, 3'd0, 2'b00, 16'h0000);
        arstn = 1'b0;
        @(negedge clk);
        check("mr_wren",    32'(bus.rf_wrEn_o),   32'd0);
        check("mr_busy",    32'(bus.busy_o),      32'd0);
        check("mr_idle",    32'(bus.idle_o),      32'd1);
        check("mr_mem_rdy", 32'(bus.mem_ready_o), 32'd0);
        cyc();
        cyc();
        arstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_post_wren", 32'(bus.rf_wrEn_o), 32'd0);
            check("mr_post_busy", 32'(bus.busy_o),    32'd0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
